mem_burst_reader: RTL
=====================

Name: mem_burst_reader

Overview:
- Sequential read engine sitting directly upstream of mainMemory port A.
- Takes a start command (base address, word count) and issues consecutive 18-bit reads.
- Captures the 24-bit read data and streams it downstream over a valid/ready interface with a last-beat flag.
- An internal credit-controlled FIFO absorbs backpressure, so no read data is ever dropped.

Parameters:
- ADDR_W, 18: main memory address width.
- DATA_W, 24: main memory word width.
- LEN_W, 18: width of the burst length field, giving a maximum of 2^18-1 words.
- FIFO_DEPTH, 4: output buffer depth in words; must be a power of two and at least 2.

Ports:
- clk  in  1  system clock. The block's registers act on the rising edge; memory is clocked on !clk.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command strobe; accepted only in IDLE.
- base_addr  in  ADDR_W  first word address, latched on an accepted start.
- length  in  LEN_W  number of words to read, latched on an accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the burst is complete.
- mem_addr  out  ADDR_W  address driven to mainMemory address_a.
- mem_wren  out  1  tied to 0; this block never writes.
- mem_q  in  DATA_W  mainMemory q_a.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  DATA_W  read word, delivered in address order.
- out_last  out  1  high with the final word of the burst.

Behaviour:
- Reset values: busy=0, done=0, mem_addr=0, mem_wren=0, out_valid=0, out_data=0, out_last=0. FIFO empty, in-flight count 0, state IDLE.
- Memory timing: mem_addr is registered at rising edge k and sampled by memory at the following falling edge. mem_q is valid at rising edge k+1, a fixed read latency of 1 cycle. A one-bit issue pipeline tags which cycles return data.
- States:
  - IDLE, when start=1 and length!=0: latch addr/remaining, go to ISSUE, busy=1.
  - IDLE, when start=1 and length=0: done pulses the next cycle, stay in IDLE, no reads issued.
  - ISSUE: issue one read per cycle while (fifo_count + inflight) < FIFO_DEPTH. Each issue sets mem_addr=addr, addr=addr+1 modulo 2^ADDR_W (262143 wraps to 0), remaining-1. The issue that takes remaining to 0 moves to DRAIN.
  - DRAIN: when inflight=0, the FIFO is empty and the last beat handshake has completed, go to IDLE, pulse done, busy=0 the same cycle.
- Returned mem_q is written into the FIFO on the cycle it is valid. The FIFO is show-ahead, so out_valid rises the cycle after the write.
- The minimum latency from start to first out_valid is 3 cycles.
- A beat transfers when out_valid && out_ready. out_data and out_last stay stable while out_valid && !out_ready.
- out_last is set on the beat whose issue decremented remaining to 0.
- Simultaneous FIFO push and pop in one cycle: the count is unchanged and both take effect.
- A start while busy is ignored; latched values are unchanged.
- The credit rule guarantees no FIFO overflow; an overflow is an assertion failure in simulation.
- rst_n asserted mid-burst: all state clears immediately, in-flight data is discarded, no done pulse. The first start after reset deassertion behaves as from power-up.

Optional Feature:
- Macro MEM_BURST_STRIDE_EN adds input port stride (ADDR_W), latched on start.
- With the macro defined: the address increments by the latched stride, modulo 2^ADDR_W; stride=0 rereads the same word.
- Without the macro: no stride port, and the increment is fixed at 1.

Decomposition:
- Shared package mem_pkg holds:
  - ADDR_W=18, DATA_W=24 and MEM_RD_LAT=1;
  - typedefs addr_t and word_t;
  - enum burst_state_t {IDLE, ISSUE, DRAIN}.
- Sub-module burst_fifo: a synchronous show-ahead FIFO with DATA_W+1 bits (data plus last), FIFO_DEPTH entries, count output, async active-low reset.

Test Plan:
- Memory preloaded with word[i]=i+100, start with base=0, length=4, out_ready=1. Expect mem_addr 0,1,2,3 on consecutive cycles, out_data 100,101,102,103 with out_last only on 103, and exactly one done pulse.
- base=10, length=8, out_ready held 0 for 12 cycles then 1. Expect only 4 addresses issued (10..13) while stalled, then all 8 words 110..117 delivered in order with none lost or duplicated.
- base=262142, length=3. Expect mem_addr sequence 262142, 262143, 0, and out_last on the word read from address 0.
- start with length=0. Expect done pulse the next cycle, out_valid never asserted and busy stays 0.
- Burst of length 6 with rst_n pulled low after 2 beats. Expect all outputs at reset values within the same cycle. A new burst with base=0, length=2 then returns 100,101 correctly.
- Second start (base=50) pulsed mid-burst. Expect it ignored: addresses continue from the original sequence and only one done pulse occurs.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared widths, latency and types for the main-memory burst reader.
package mem_pkg;
  localparam int ADDR_W     = 18;
  localparam int DATA_W     = 24;
  localparam int MEM_RD_LAT = 1;

  typedef logic [ADDR_W-1:0]     addr_t;
  typedef logic [DATA_W-1:0]     word_t;
  typedef logic [MEM_RD_LAT-1:0] rd_pipe_t;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} burst_state_t;
endpackage

// File: rtl/burst_fifo.sv
// Show-ahead FIFO: dout presents the oldest entry whenever valid is high.
module burst_fifo #(
  parameter int W     = 25,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     dout,
  output logic             valid,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             pop_ok;

  assign valid  = (count != '0);
  assign pop_ok = pop && valid;
  assign dout   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push && !pop_ok) assert (count != CNT_W'(DEPTH));
  end
endmodule

// File: rtl/mem_burst_reader.sv
// Sequential burst read engine for mainMemory port A, streaming words over valid/ready.
// Define MEM_BURST_STRIDE_EN to add a per-burst address stride input.
module mem_burst_reader
  import mem_pkg::*;
#(
  parameter int ADDR_W     = mem_pkg::ADDR_W,
  parameter int DATA_W     = mem_pkg::DATA_W,
  parameter int LEN_W      = 18,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
`ifdef MEM_BURST_STRIDE_EN
  input  logic [ADDR_W-1:0] stride,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output burst_state_t      dbg_state
);
  // Handshake: a beat moves on a rising edge where out_valid && out_ready;
  // while out_valid && !out_ready, out_data and out_last are held.
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  burst_state_t      state, state_n;
  logic [ADDR_W-1:0] addr_r, step;
  logic [LEN_W-1:0]  rem_r;
  rd_pipe_t          rd_vld, rd_last;
  logic              accept, issue, finish, zero_len, fifo_pop;
  logic [CNT_W-1:0]  fifo_count, credit_used;
  logic [DATA_W:0]   fifo_dout;

`ifdef MEM_BURST_STRIDE_EN
  logic [ADDR_W-1:0] stride_r;
  assign step = stride_r;
`else
  assign step = ADDR_W'(1);
`endif

  // Words already buffered plus reads still returning must never exceed the FIFO.
  assign credit_used = fifo_count + CNT_W'($countones(rd_vld));
  assign zero_len    = (state == IDLE) && start && (length == '0);

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    issue   = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE: begin
        if (start && length != '0) begin
          accept  = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (credit_used < CNT_W'(FIFO_DEPTH)) begin
          issue = 1'b1;
          if (rem_r == LEN_W'(1)) state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (rd_vld == '0 && fifo_count == '0) begin
          finish  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r   <= '0;
      rem_r    <= '0;
      mem_addr <= '0;
      rd_vld   <= '0;
      rd_last  <= '0;
      done     <= 1'b0;
`ifdef MEM_BURST_STRIDE_EN
      stride_r <= '0;
`endif
    end else begin
      done    <= finish || zero_len;
      rd_vld  <= rd_pipe_t'(issue);
      rd_last <= rd_pipe_t'(issue && rem_r == LEN_W'(1));
      if (accept) begin
        addr_r   <= base_addr;
        rem_r    <= length;
`ifdef MEM_BURST_STRIDE_EN
        stride_r <= stride;
`endif
      end
      if (issue) begin
        mem_addr <= addr_r;
        addr_r   <= addr_r + step;
        rem_r    <= rem_r - LEN_W'(1);
      end
    end
  end

  assign fifo_pop  = out_valid && out_ready;
  assign busy      = (state != IDLE);
  assign mem_wren  = 1'b0;
  assign dbg_state = state;
  assign {out_last, out_data} = fifo_dout;

  burst_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rd_vld[MEM_RD_LAT-1]),
    .din   ({rd_last[MEM_RD_LAT-1], mem_q}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .valid (out_valid),
    .count (fifo_count)
  );
endmodule
